// File: rtl/UART_CONSTANTS.sv
// Shared UART constants: parity selection and the parity-bit rule used by the serial blocks.
package UART_CONSTANTS;
  typedef enum logic [2:0] {
    UART_PARITY_NONE,
    UART_PARITY_EVEN,
    UART_PARITY_ODD,
    UART_PARITY_MARK,
    UART_PARITY_SPACE
  } uart_parity_t;

  // Narrow characters are zero-extended by the caller; zeros do not disturb the XOR.
  function automatic logic parity_bit(uart_parity_t kind, logic [7:0] bits);
    case (kind)
      UART_PARITY_EVEN: return ^bits;
      UART_PARITY_ODD:  return ~^bits;
      UART_PARITY_MARK: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// Input FIFO for uart_tx: show-ahead read (dout valid while !empty), written data visible next cycle.
// Backpressure via full/empty only; push while full or pop while empty is dropped.
module uart_tx_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter (start, LSB-first data, optional parity, stop bits); UART_TX_FIFO_EN adds a 4-deep input FIFO.
// tx falls on the edge after acceptance (one edge later via the FIFO); ready drops while a frame or a full FIFO is pending.
module uart_tx
  import UART_CONSTANTS::*;
#(
  parameter int           data_width        = 8,
  parameter int           oversampling_rate = 8,
  parameter uart_parity_t parity_type       = UART_PARITY_NONE,
  parameter int           stop_bits         = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [data_width-1:0] data,
  input  logic                  data_valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_TICK = 4'(oversampling_rate - 1);
  localparam logic [2:0] LAST_DATA = 3'(data_width - 1);
  localparam logic [2:0] LAST_STOP = 3'(stop_bits - 1);

  state_t                state, state_d;
  logic [3:0]            tick, tick_d;
  logic [2:0]            idx, idx_d;
  logic [data_width-1:0] shreg, shreg_d;
  logic                  par, par_d;
  logic                  tx_d;
  logic                  bit_end, stop_end;
  logic                  char_avail, take;
  logic [data_width-1:0] char_dat;

`ifdef UART_TX_FIFO_EN
  logic fifo_full, fifo_empty;

  assign ready      = !reset && !fifo_full;
  assign char_avail = !fifo_empty;

  uart_tx_fifo #(.width(data_width), .depth(4)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (data_valid && ready),
    .din  (data),
    .pop  (take),
    .dout (char_dat),
    .full (fifo_full),
    .empty(fifo_empty)
  );
`else
  assign ready      = !reset && (state == IDLE);
  assign char_avail = data_valid && ready;
  assign char_dat   = data;
`endif

  assign bit_end  = (tick == LAST_TICK);
  assign stop_end = (state == STOP) && bit_end && (idx == LAST_STOP);
  assign busy     = (state != IDLE);

  always_comb begin
    state_d = state;
    tick_d  = tick + 4'd1;
    idx_d   = idx;
    shreg_d = shreg;
    par_d   = par;
    take    = 1'b0;
    tx_d    = 1'b1;
    case (state)
      IDLE: begin
        tick_d = '0;
        if (char_avail) begin
          take    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tick_d  = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shreg_d = shreg >> 1;
          if (idx == LAST_DATA) begin
            idx_d   = '0;
            state_d = (parity_type == UART_PARITY_NONE) ? STOP : PARITY;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          idx_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          tick_d = '0;
          if (stop_end) begin
            // Only the FIFO build can have a character waiting here.
            if (char_avail) begin
              take    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      shreg_d = char_dat;
      par_d   = parity_bit(parity_type, 8'(char_dat));
      idx_d   = '0;
    end

    // tx is registered from the next state so the line changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      tick  <= '0;
      idx   <= '0;
      shreg <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      tick  <= tick_d;
      idx   <= idx_d;
      shreg <= shreg_d;
      par   <= par_d;
      tx    <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations checked every cycle against a frame-level model plus literal frame checks.
module tb_uart_tx;
  import UART_CONSTANTS::*;

  localparam int N  = 4;
  localparam int OS = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dv   [N];
  logic [7:0] dat  [N];
  logic       rdy  [N];
  logic       txo  [N];
  logic       bsy  [N];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  uart_tx #(.data_width(8)) u0 (
    .clock(clock), .reset(reset), .data(dat[0]), .data_valid(dv[0]),
    .ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]));
  uart_tx #(.data_width(8), .parity_type(UART_PARITY_EVEN)) u1 (
    .clock(clock), .reset(reset), .data(dat[1]), .data_valid(dv[1]),
    .ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]));
  uart_tx #(.data_width(8), .parity_type(UART_PARITY_ODD)) u2 (
    .clock(clock), .reset(reset), .data(dat[2]), .data_valid(dv[2]),
    .ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]));
  uart_tx #(.data_width(5), .stop_bits(2)) u3 (
    .clock(clock), .reset(reset), .data(dat[3][4:0]), .data_valid(dv[3]),
    .ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]));

  function automatic int cfg_dw(int i);
    return (i == 3) ? 5 : 8;
  endfunction
  function automatic int cfg_sb(int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic uart_parity_t cfg_par(int i);
    case (i)
      1:       return UART_PARITY_EVEN;
      2:       return UART_PARITY_ODD;
      default: return UART_PARITY_NONE;
    endcase
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [u%0d]: got 0x%0h expected 0x%0h at t=%0t", name, i, act, exp, $time);
    end
  endtask

  // Frame model: a list of line bits per character and a cycle position within it.
  logic [15:0] m_bits [N];
  int          m_len  [N];
  int          m_pos  [N];
  bit          m_act  [N];
`ifdef UART_TX_FIFO_EN
  logic [7:0]  m_q    [N][4];
  int          m_cnt  [N];
`endif

  task automatic build_frame(input int i, input logic [7:0] d);
    logic [15:0] b;
    int n, ones;
    b = '1;
    b[0] = 1'b0;
    n = 1;
    ones = 0;
    for (int k = 0; k < cfg_dw(i); k++) begin
      b[n] = d[k];
      if (d[k]) ones++;
      n++;
    end
    case (cfg_par(i))
      UART_PARITY_EVEN:  begin b[n] = (ones % 2 == 1); n++; end
      UART_PARITY_ODD:   begin b[n] = (ones % 2 == 0); n++; end
      UART_PARITY_MARK:  begin b[n] = 1'b1; n++; end
      UART_PARITY_SPACE: begin b[n] = 1'b0; n++; end
      default: ;
    endcase
    n += cfg_sb(i);
    m_bits[i] = b;
    m_len[i]  = n * OS;
    m_pos[i]  = 0;
    m_act[i]  = 1'b1;
  endtask

  always @(posedge clock) begin : model
    bit free, fin, pushed;
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_act[i] = 1'b0;
`ifdef UART_TX_FIFO_EN
        m_cnt[i] = 0;
`endif
      end else begin
        free = !m_act[i];
        fin  = 1'b0;
`ifdef UART_TX_FIFO_EN
        pushed = dv[i] && (m_cnt[i] < 4);
`else
        pushed = 1'b0;
`endif
        if (m_act[i]) begin
          m_pos[i]++;
          if (m_pos[i] == m_len[i]) begin
            m_act[i] = 1'b0;
            fin = 1'b1;
          end
        end
`ifdef UART_TX_FIFO_EN
        if ((free || fin) && m_cnt[i] > 0) begin
          build_frame(i, m_q[i][0]);
          for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
          m_cnt[i]--;
        end
        if (pushed) begin
          m_q[i][m_cnt[i]] = dat[i];
          m_cnt[i]++;
        end
`else
        if (free && dv[i] && !pushed) build_frame(i, dat[i]);
`endif
      end
    end
  end

  always @(negedge clock) begin : compare
    logic exp_tx, exp_rdy;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        exp_tx = m_act[i] ? m_bits[i][m_pos[i] / OS] : 1'b1;
`ifdef UART_TX_FIFO_EN
        exp_rdy = !reset && (m_cnt[i] < 4);
`else
        exp_rdy = !reset && !m_act[i];
`endif
        check("tx", i, 32'(txo[i]), 32'(exp_tx));
        check("busy", i, 32'(bsy[i]), 32'(m_act[i]));
        check("ready", i, 32'(rdy[i]), 32'(exp_rdy));
      end
    end
  end

  logic tr_tx  [1024];
  logic tr_bsy [1024];

  task automatic send(input int i, input logic [7:0] d);
    @(posedge clock); #1;
    dv[i] = 1'b1;
    dat[i] = d;
    @(posedge clock); #1;
    dv[i] = 1'b0;
  endtask

  task automatic capture(input int i, input int ncyc);
    int w;
    w = 0;
    @(negedge clock);
    while (bsy[i] !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("busy_rise", i, 32'(bsy[i]), 32'd1);
    for (int c = 0; c < ncyc; c++) begin
      tr_tx[c]  = txo[i];
      tr_bsy[c] = bsy[i];
      @(negedge clock);
    end
  endtask

  function automatic int busy_run(int ncyc);
    int c;
    c = 0;
    while (c < ncyc && tr_bsy[c] === 1'b1) c++;
    return c;
  endfunction

  function automatic logic [15:0] bits_of(int nb);
    logic [15:0] b;
    b = '0;
    for (int k = 0; k < nb; k++) b[k] = tr_tx[k*OS + OS/2];
    return b;
  endfunction

  function automatic int high_busy(int ncyc);
    int n;
    n = 0;
    for (int c = 0; c < ncyc; c++) if (tr_tx[c] === 1'b1 && tr_bsy[c] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      dv[i] = 1'b0;
      dat[i] = 8'h00;
    end
    @(posedge clock); #1;
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_tx", 0, 32'(txo[0]), 32'd1);
    check("rst_busy", 0, 32'(bsy[0]), 32'd0);
    check("rst_ready", 0, 32'(rdy[0]), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", 0, 32'(rdy[0]), 32'd1);

    // 8N1 0x55
    send(0, 8'h55);
    capture(0, 100);
    check("frame_55", 0, 32'(bits_of(10)), 32'h2AA);
    check("len_55", 0, busy_run(100), 80);
    check("start_end", 0, 32'(tr_tx[7]), 32'd0);
    check("d0_begin", 0, 32'(tr_tx[8]), 32'd1);

    // parity
    send(1, 8'h07);
    capture(1, 100);
    check("even_par", 1, 32'(tr_tx[9*OS + 4]), 32'd1);
    check("frame_07", 1, 32'(bits_of(11)), 32'h60E);
    check("len_even", 1, busy_run(100), 88);
    send(2, 8'h00);
    capture(2, 100);
    check("odd_par", 2, 32'(tr_tx[9*OS + 4]), 32'd1);
    check("frame_00", 2, 32'(bits_of(11)), 32'h600);
    check("len_odd", 2, busy_run(100), 88);

    // 5 data bits, 2 stop bits
    send(3, 8'h1F);
    capture(3, 80);
    check("frame_1f", 3, 32'(bits_of(8)), 32'hFE);
    check("len_5n2", 3, busy_run(80), 64);
    send(3, 8'h00);
    capture(3, 80);
    check("stop_high", 3, high_busy(80), 16);

    // reset mid-frame, then a clean 0xA5
    send(0, 8'h3C);
    capture(0, 19);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_tx", 0, 32'(txo[0]), 32'd1);
    check("mid_rst_busy", 0, 32'(bsy[0]), 32'd0);
    check("mid_rst_ready", 0, 32'(rdy[0]), 32'd1);
    send(0, 8'hA5);
    capture(0, 100);
    check("frame_a5", 0, 32'(bits_of(10)), 32'h34A);
    check("len_a5", 0, busy_run(100), 80);

`ifdef UART_TX_FIFO_EN
    // six pushes from IDLE: five accepted, frames back-to-back
    @(posedge clock); #1;
    dv[0] = 1'b1;
    dat[0] = 8'h01;
    for (int v = 2; v <= 6; v++) begin
      @(posedge clock); #1;
      dat[0] = 8'(v);
    end
    @(negedge clock);
    check("fifo_full_ready", 0, 32'(rdy[0]), 32'd0);
    @(posedge clock); #1;
    dv[0] = 1'b0;
    for (int c = 0; c < 450; c++) begin
      @(negedge clock);
      tr_tx[c]  = txo[0];
      tr_bsy[c] = bsy[0];
    end
    check("b2b_busy", 0, busy_run(450), 396);
    for (int k = 1; k < 5; k++) check("b2b_start", 0, 32'(tr_tx[80*k]), 32'd0);
`else
    // data_valid held with changing data: captured char is kept, next accept after IDLE
    @(posedge clock); #1;
    dv[0] = 1'b1;
    dat[0] = 8'h81;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock); #1;
      dat[0] = 8'(c * 37 + 5);
      @(negedge clock);
      tr_tx[c]  = txo[0];
      tr_bsy[c] = bsy[0];
    end
    dv[0] = 1'b0;
    check("held_frame", 0, 32'(bits_of(10)), 32'h302);
    check("held_len", 0, busy_run(200), 80);
    check("idle_gap", 0, 32'(tr_bsy[80]), 32'd0);
    check("next_accept", 0, 32'(tr_bsy[81]), 32'd1);
`endif

    repeat (120) @(posedge clock);
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
